// File: rtl/snn_noc_pkg.sv
// Shared definitions for the SNN network-on-chip spike path.
// Contents: TX FSM state encoding, spike packet field positions,
// default cluster identifier, and a helper that assembles a packet word.
package snn_noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } tx_state_e;

  localparam logic [7:0] CLUSTER_ID_DEFAULT = 8'h00;

  // Packet word layout
  localparam int PKT_W        = 32;
  localparam int PKT_CID_LSB  = 24;
  localparam int PKT_TS_LSB   = 16;
  localparam int PKT_NID_LSB  = 8;
  localparam int PKT_LAST_BIT = 0;

  function automatic logic [PKT_W-1:0] make_pkt(input logic [7:0] cid,
                                                input logic [7:0] ts,
                                                input logic [7:0] nid,
                                                input logic       last);
    logic [PKT_W-1:0] w;
    w = '0;
    w[PKT_CID_LSB +: 8]  = cid;
    w[PKT_TS_LSB  +: 8]  = ts;
    w[PKT_NID_LSB +: 8]  = nid;
    w[PKT_LAST_BIT]      = last;
    return w;
  endfunction

endpackage

// File: rtl/spike_packet_tx_if.sv
// Spike packet channel towards the NoC router (valid/ready handshake).
//   pkt_valid : word available (master -> slave)
//   pkt_ready : router accepts the word (slave -> master)
//   pkt_data  : 32-bit spike packet word (master -> slave)
interface spike_packet_tx_if;
  import snn_noc_pkg::*;

  logic             pkt_valid;
  logic             pkt_ready;
  logic [PKT_W-1:0] pkt_data;

  modport master (output pkt_valid, output pkt_data, input  pkt_ready);
  modport slave  (input  pkt_valid, input  pkt_data, output pkt_ready);
endinterface

// File: rtl/spike_priority_enc.sv
// Combinational lowest-set-bit finder over the pending spike mask.
//   mask     : pending neuron bits
//   index    : index of the lowest set bit (0 when mask is empty)
//   valid    : any bit set
//   only_one : exactly one bit set
module spike_priority_enc #(
  parameter int N     = 20,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] index,
  output logic             valid,
  output logic             only_one
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--)
      if (mask[i]) index = IDX_W'(i);
  end

  assign valid    = |mask;
  // Clearing the lowest set bit leaves nothing only if it was the sole bit.
  assign only_one = valid && ((mask & (mask - N'(1))) == '0);

endmodule

// File: rtl/spike_packet_tx.sv
// Spike packet transmitter for one neuron cluster.
// On ts_done the spike vector is captured and each set neuron is sent to
// the NoC as one packet word, lowest index first, one word per cycle.
//   clk, clear           : clock, synchronous active-high reset
//   spike_vec, timestep  : sampled on ts_done
//   ts_done              : timestep-end pulse
//   pkt                  : packet channel (master side)
//   busy                 : captured spikes still being transmitted
//   done                 : one-cycle pulse after the last packet
//   overrun              : sticky, ts_done seen while not idle
module spike_packet_tx
  import snn_noc_pkg::*;
#(
  parameter int         NUM_NEURONS = 20,
  parameter logic [7:0] CLUSTER_ID  = CLUSTER_ID_DEFAULT,
  parameter int         TS_W        = 8
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic [NUM_NEURONS-1:0] spike_vec,
  input  logic                   ts_done,
  input  logic [TS_W-1:0]        timestep,
  spike_packet_tx_if.master      pkt,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  tx_state_e              state, state_nxt;
  logic [NUM_NEURONS-1:0] mask;
  logic [TS_W-1:0]        ts_reg;
  logic                   had_spikes;
  logic [IDX_W-1:0]       enc_idx;
  logic                   enc_valid, enc_only;
  logic [7:0]             ts8, idx8;
  logic                   accept;

  spike_priority_enc #(.N(NUM_NEURONS), .IDX_W(IDX_W)) u_enc (
    .mask     (mask),
    .index    (enc_idx),
    .valid    (enc_valid),
    .only_one (enc_only)
  );

  // Fit timestep and neuron index into their 8-bit packet fields.
  if (TS_W >= 8) begin : g_ts_trunc
    assign ts8 = ts_reg[7:0];
  end else begin : g_ts_ext
    assign ts8 = {{(8-TS_W){1'b0}}, ts_reg};
  end

  if (IDX_W >= 8) begin : g_idx_trunc
    assign idx8 = enc_idx[7:0];
  end else begin : g_idx_ext
    assign idx8 = {{(8-IDX_W){1'b0}}, enc_idx};
  end

  assign accept = pkt.pkt_valid && pkt.pkt_ready;

  // State register
  always_ff @(posedge clk) begin
    if (clear) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ts_done) state_nxt = (|spike_vec) ? ST_SEND : ST_DONE;
      ST_SEND: if (accept && enc_only) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    pkt.pkt_valid = (state == ST_SEND) && enc_valid;
    pkt.pkt_data  = '0;
    if (pkt.pkt_valid) pkt.pkt_data = make_pkt(CLUSTER_ID, ts8, idx8, enc_only);
    // An empty capture never had anything pending, so its DONE cycle is not busy.
    busy = (state == ST_SEND) || ((state == ST_DONE) && had_spikes);
    done = (state == ST_DONE);
  end

  // Capture / pending-mask datapath
  always_ff @(posedge clk) begin
    if (clear) begin
      mask       <= '0;
      ts_reg     <= '0;
      had_spikes <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (ts_done && state == ST_IDLE) begin
        mask       <= spike_vec;
        ts_reg     <= timestep;
        had_spikes <= |spike_vec;
      end
      if (ts_done && state != ST_IDLE) overrun <= 1'b1;
      // Drop the lowest pending bit once its packet is taken.
      if (accept) mask <= mask & (mask - NUM_NEURONS'(1));
    end
  end

endmodule

// File: tb/tb_spike_packet_tx.sv
module tb_spike_packet_tx;
  import snn_noc_pkg::*;

  localparam int N = 20;
  localparam logic [7:0] CID = CLUSTER_ID_DEFAULT;

  logic         clk = 1'b0;
  logic         clear;
  logic [N-1:0] spike_vec;
  logic         ts_done;
  logic [7:0]   timestep;
  logic         busy, done, overrun;

  int  tests = 0;
  int  fails = 0;
  bit  exp_ovr = 0;

  spike_packet_tx_if pkt_if ();

  spike_packet_tx #(.NUM_NEURONS(N), .TS_W(8)) dut (
    .clk       (clk),
    .clear     (clear),
    .spike_vec (spike_vec),
    .ts_done   (ts_done),
    .timestep  (timestep),
    .pkt       (pkt_if),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One timestep: capture vec/ts, drain packets under the chosen ready
  // pattern (0: always ready, 1: random, 2: stall 4 cycles then ready),
  // optionally firing a stray ts_done during SEND or on the DONE cycle.
  task automatic run_ts(input logic [N-1:0] vec, input logic [7:0] ts, input int mode,
                        input bit inj_send, input bit inj_done);
    logic [31:0] q[$];
    int hi, cyc;
    bit rdy;
    hi = -1;
    for (int i = 0; i < N; i++) if (vec[i]) hi = i;
    for (int i = 0; i < N; i++)
      if (vec[i]) q.push_back({CID, ts, 8'(i), 7'd0, 1'(i == hi)});

    spike_vec = vec; timestep = ts; ts_done = 1'b1;
    tick();
    ts_done = 1'b0;
    spike_vec = N'($urandom); timestep = 8'($urandom);
    cyc = 0;
    while (q.size() > 0) begin
      chk("send_valid", 32'(pkt_if.pkt_valid), 32'd1);
      chk("send_data",  pkt_if.pkt_data, q[0]);
      chk("send_busy",  32'(busy), 32'd1);
      chk("send_done",  32'(done), 32'd0);
      chk("send_ovr",   32'(overrun), 32'(exp_ovr));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 1) == 1) || (cyc > 200);
        default: rdy = (cyc >= 4);
      endcase
      pkt_if.pkt_ready = rdy;
      if (inj_send && cyc == 0) begin
        ts_done = 1'b1; spike_vec = N'($urandom); timestep = 8'($urandom);
      end
      tick();
      ts_done = 1'b0;
      if (inj_send && cyc == 0) exp_ovr = 1'b1;
      if (rdy) void'(q.pop_front());
      cyc++;
    end
    // Ready with nothing valid must be harmless.
    pkt_if.pkt_ready = 1'($urandom);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_valid", 32'(pkt_if.pkt_valid), 32'd0);
    chk("done_busy",  32'(busy), 32'(vec != '0));
    chk("done_ovr",   32'(overrun), 32'(exp_ovr));
    if (inj_done) begin
      ts_done = 1'b1; spike_vec = 20'h00001; timestep = 8'h77;
    end
    tick();
    ts_done = 1'b0;
    if (inj_done) exp_ovr = 1'b1;
    chk("idle_done",  32'(done), 32'd0);
    chk("idle_valid", 32'(pkt_if.pkt_valid), 32'd0);
    chk("idle_busy",  32'(busy), 32'd0);
    chk("idle_data",  pkt_if.pkt_data, 32'd0);
    chk("idle_ovr",   32'(overrun), 32'(exp_ovr));
    tick();
    chk("idle2_valid", 32'(pkt_if.pkt_valid), 32'd0);
    chk("idle2_done",  32'(done), 32'd0);
  endtask

  initial begin
    logic [N-1:0] v;
    clear = 1'b1; ts_done = 1'b0; spike_vec = '0; timestep = '0;
    pkt_if.pkt_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(pkt_if.pkt_valid), 32'd0);
    chk("rst_data",  pkt_if.pkt_data, 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_ovr",   32'(overrun), 32'd0);
    clear = 1'b0;
    tick();

    // Two spikes, router always ready
    run_ts(20'h00005, 8'h03, 0, 0, 0);
    // Same stimulus with a 4-cycle stall on the first word
    run_ts(20'h00005, 8'h03, 2, 0, 0);
    // Empty timestep
    run_ts(20'h00000, 8'h10, 0, 0, 0);
    // Every neuron fires
    run_ts(20'hFFFFF, 8'h42, 0, 0, 0);
    // Stray ts_done during SEND
    run_ts(20'h00005, 8'h03, 0, 1, 0);
    // Stray ts_done on the DONE cycle
    run_ts(20'h00300, 8'h09, 1, 0, 1);

    // clear during the third packet of a full burst
    spike_vec = 20'hFFFFF; timestep = 8'h55; ts_done = 1'b1;
    pkt_if.pkt_ready = 1'b1;
    tick();
    ts_done = 1'b0;
    tick(); tick();
    chk("clr_third", pkt_if.pkt_data, {CID, 8'h55, 8'd2, 8'h00});
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_ovr = 1'b0;
    chk("clr_valid", 32'(pkt_if.pkt_valid), 32'd0);
    chk("clr_busy",  32'(busy), 32'd0);
    chk("clr_ovr",   32'(overrun), 32'd0);
    chk("clr_done",  32'(done), 32'd0);
    tick();
    chk("clr_done2",  32'(done), 32'd0);
    chk("clr_valid2", 32'(pkt_if.pkt_valid), 32'd0);

    // Randomized timesteps
    for (int it = 0; it < 16; it++) begin
      case (it % 4)
        0:       v = N'(1) << $urandom_range(0, N - 1);
        1:       v = '0;
        default: v = N'($urandom);
      endcase
      run_ts(v, 8'($urandom), $urandom_range(0, 2), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
